// File: rtl/gate_tt_checker.sv
// Self-test initiator for a 2-input gate: walks {a,b} through 00..11, lets each vector
// settle, samples y, and grades it against TRUTH_TABLE (bit i = expected y for {a,b}=i).
module gate_tt_checker #(
    parameter logic [3:0]  TRUTH_TABLE   = 4'b0111,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec,
    output logic [2:0] err_cnt,
    output logic [1:0] dbg_state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] fail_vec_q, fail_vec_d;
    logic [2:0] err_cnt_q, err_cnt_d;
    logic       mismatch;

    assign mismatch = (y != TRUTH_TABLE[idx_q]);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        fail_vec_d = fail_vec_q;
        err_cnt_d  = err_cnt_q;

        case (state_q)
            S_IDLE: begin
                a_d    = 1'b0;
                b_d    = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    state_d    = S_SETTLE;
                    idx_d      = 2'd0;
                    cnt_d      = 8'd0;
                    fail_vec_d = 4'b0000;
                    err_cnt_d  = 3'd0;
                    pass_d     = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = S_SAMPLE;
                    end
                end
            end
            S_SAMPLE: begin
                // An abort on the sample edge throws this sample away.
                if (abort) begin
                    state_d = S_IDLE;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                    cnt_d   = 8'd0;
                end else begin
                    if (mismatch) begin
                        fail_vec_d[idx_q] = 1'b1;
                        err_cnt_d         = err_cnt_q + 3'd1;
                    end
                    if (idx_q != 2'd3) begin
                        idx_d        = idx_q + 2'd1;
                        {a_d, b_d}   = idx_q + 2'd1;
                        cnt_d        = 8'd0;
                        state_d      = S_SETTLE;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                        pass_d  = (err_cnt_q == 3'd0) && !mismatch;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= 2'd0;
            cnt_q      <= 8'd0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_vec_q <= 4'b0000;
            err_cnt_q  <= 3'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_vec_q <= fail_vec_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_vec  = fail_vec_q;
    assign err_cnt   = err_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Bench for gate_tt_checker: directed runs against NAND / stuck-at-1 / AND gates,
// a cycle-level behavioural model compared every negedge, plus literal spot checks.
module tb_gate_tt_checker;

    localparam int S   = 2;
    localparam int P   = S + 1;
    localparam int RUN = 4 * P;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, y;
    logic       a, b, busy, done, pass;
    logic [3:0] fail_vec;
    logic [2:0] err_cnt;
    logic [1:0] dbg_state;

    logic       start2, abort2, y2;
    logic       a2, b2, busy2, done2, pass2;
    logic [3:0] fail_vec2;
    logic [2:0] err_cnt2;
    logic [1:0] dbg_state2;

    int mode = 0;  // 0: NAND, 1: stuck-at-1, 2: AND

    int checks = 0;
    int errors = 0;

    function automatic logic gate_fn(input int md, input logic [1:0] v);
        case (md)
            0:       return !(v[1] & v[0]);
            1:       return 1'b1;
            default: return v[1] & v[0];
        endcase
    endfunction

    assign y  = gate_fn(mode, {a, b});
    assign y2 = a2 & b2;

    always #5 clk = ~clk;

    gate_tt_checker u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .y(y),
        .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
        .fail_vec(fail_vec), .err_cnt(err_cnt), .dbg_state(dbg_state)
    );

    gate_tt_checker #(.TRUTH_TABLE(4'b1000), .SETTLE_CYCLES(S)) u_dut_and (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .y(y2),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2),
        .fail_vec(fail_vec2), .err_cnt(err_cnt2), .dbg_state(dbg_state2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: a run is "edges since start accepted"; vector v is held for
    // edges [v*P, (v+1)*P) and graded on edge (v+1)*P; done follows edge 4*P.
    logic [3:0] tt_v = 4'b0111;
    bit         m_active = 1'b0;
    int         m_n = 0;
    logic [3:0] m_fv = 4'b0000;
    logic       m_pass = 1'b0;
    logic       start_s = 1'b0;
    logic       abort_s = 1'b0;
    bit         cmp_en = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_n      = 0;
            m_fv     = 4'b0000;
            m_pass   = 1'b0;
        end else if (m_active) begin
            if (abort_s && m_n < RUN) begin
                m_active = 1'b0;
                m_pass   = 1'b0;
            end else if (m_n == RUN) begin
                m_active = 1'b0;
            end else begin
                m_n++;
                if (m_n % P == 0) begin
                    logic [1:0] v;
                    v = 2'(m_n / P - 1);
                    if (gate_fn(mode, v) != tt_v[v]) m_fv[v] = 1'b1;
                end
                if (m_n == RUN) m_pass = (m_fv == 4'b0000);
            end
        end else if (start_s) begin
            m_active = 1'b1;
            m_n      = 0;
            m_fv     = 4'b0000;
            m_pass   = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic       e_busy, e_done;
        logic [1:0] e_ab;
        e_busy = m_active && (m_n < RUN);
        e_done = m_active && (m_n == RUN);
        e_ab   = e_busy ? 2'(m_n / P) : 2'b00;
        if (cmp_en) begin
            check("m_busy", busy, e_busy);
            check("m_done", done, e_done);
            check("m_ab", {a, b}, e_ab);
            check("m_pass", pass, m_pass);
            check("m_fail_vec", fail_vec, m_fv);
            check("m_err_cnt", err_cnt, $countones(m_fv));
        end
        start_s = start;
        abort_s = abort;
    end

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        check("done_seen", done, 1'b1);
    endtask

    task automatic run_once();
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        check("done_latency", n, RUN);
        tick();
        tick();
    endtask

    initial begin
        int n, ndone, last_t, first_t;
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        start2 = 1'b0;
        abort2 = 1'b0;
        mode   = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_fail_vec", fail_vec, 4'b0000);
        check("rst_err_cnt", err_cnt, 3'd0);
        check("rst_ab", {a, b}, 2'b00);
        cmp_en = 1'b1;
        rst_n = 1'b1;
        tick();

        // NAND gate, full run with literal timing points
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_busy_e0", busy, 1'b1);
        check("t1_ab_e0", {a, b}, 2'b00);
        repeat (3) tick();
        check("t1_ab_e3", {a, b}, 2'b01);
        repeat (3) tick();
        check("t1_ab_e6", {a, b}, 2'b10);
        repeat (3) tick();
        check("t1_ab_e9", {a, b}, 2'b11);
        repeat (3) tick();
        check("t1_done_e12", done, 1'b1);
        check("t1_pass", pass, 1'b1);
        check("t1_fail_vec", fail_vec, 4'b0000);
        check("t1_err_cnt", err_cnt, 3'd0);
        check("t1_busy_e12", busy, 1'b0);
        tick();
        check("t1_done_e13", done, 1'b0);
        check("t1_pass_hold", pass, 1'b1);
        tick();

        // Stuck-at-1 gate
        mode = 1;
        run_once();
        check("t2_fail_vec", fail_vec, 4'b1000);
        check("t2_err_cnt", err_cnt, 3'd1);
        check("t2_pass", pass, 1'b0);

        // AND gate against NAND table
        mode = 2;
        run_once();
        check("t3_fail_vec", fail_vec, 4'b1111);
        check("t3_err_cnt", err_cnt, 3'd4);
        check("t3_pass", pass, 1'b0);
        mode = 0;

        // AND gate against AND table
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 100) begin
            tick();
            n++;
        end
        check("t3b_latency", n, RUN);
        check("t3b_pass", pass2, 1'b1);
        check("t3b_fail_vec", fail_vec2, 4'b0000);
        check("t3b_err_cnt", err_cnt2, 3'd0);
        tick();

        // start held high for 40 cycles
        ndone = 0;
        first_t = -1;
        last_t = -1;
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) begin
                ndone++;
                if (first_t < 0) first_t = i;
                else last_t = i;
                check("t4_pass", pass, 1'b1);
            end
        end
        start = 1'b0;
        check("t4_done_count", ndone, 2);
        check("t4_spacing", last_t - first_t, RUN + 2);
        wait_done(n);
        tick();
        tick();

        // start pulse during busy must not queue a second run
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) ndone++;
        end
        check("t4_busy_start_ignored", ndone, 1);

        // abort during SETTLE of vector 2
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        check("t5_ab_pre", {a, b}, 2'b10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_busy", busy, 1'b0);
        check("t5_ab", {a, b}, 2'b00);
        check("t5_pass", pass, 1'b0);
        check("t5_fail_vec", fail_vec, 4'b0000);
        check("t5_err_cnt", err_cnt, 3'd0);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) ndone++;
        end
        check("t5_no_done", ndone, 0);
        run_once();
        check("t5_rerun_pass", pass, 1'b1);

        // asynchronous reset mid-run
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("t6_ab_pre", {a, b}, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_busy", busy, 1'b0);
        check("t6_ab", {a, b}, 2'b00);
        check("t6_done", done, 1'b0);
        check("t6_pass", pass, 1'b0);
        check("t6_fail_vec", fail_vec, 4'b0000);
        check("t6_err_cnt", err_cnt, 3'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (busy) n++;
        end
        check("t6_idle_after_reset", n, 0);
        run_once();
        check("t6_rerun_pass", pass, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
